// File: rtl/priority_src_if.sv
// Request/steering bundle between the priority_src arbiter and its neighbours.
// The slave modport is the arbiter; the master side raises requests and returns f.
interface priority_src_if;
  logic [3:0] req;
  logic       abort;
  logic       f;
  logic       do_run;   // run strobe ("do") to the downstream FSM
  logic [1:0] sel;
  logic [1:0] grant;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output req, abort, f,
    input  do_run, sel, grant, busy, done, err
  );

  modport slave (
    input  req, abort, f,
    output do_run, sel, grant, busy, done, err
  );
endinterface

// File: rtl/priority_src.sv
// Four-source sticky request arbiter that sequences do/sel for the downstream
// control FSM, using its f flag as the completion acknowledge.
module priority_src #(
  parameter int unsigned RUN_LEN  = 4,
  parameter int unsigned WAIT_MAX = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  priority_src_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    COMMIT = 2'd2,
    CANCEL = 2'd3
  } state_t;

  localparam logic [1:0] SEL_NEUTRAL = 2'd0;
  localparam logic [1:0] SEL_CANCEL  = 2'd2;
  localparam logic [1:0] SEL_COMMIT  = 2'd3;
  localparam logic [7:0] RUN_LOAD    = 8'(RUN_LEN - 1);
  localparam logic [7:0] WAIT_LOAD   = 8'(WAIT_MAX - 1);

  state_t     state_q, state_d;
  logic [3:0] pend_q;
  logic [3:0] clr;
  logic [7:0] cnt_q, cnt_d;
  logic       do_q, do_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] grant_q, grant_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  function automatic logic [1:0] top_bit(input logic [3:0] v);
    if (v[3])      return 2'd3;
    else if (v[2]) return 2'd2;
    else if (v[1]) return 2'd1;
    else           return 2'd0;
  endfunction

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    do_d    = do_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    clr     = 4'b0000;

    case (state_q)
      IDLE: begin
        // pend_q is the pre-merge value, so a same-cycle req waits one extra cycle.
        if (pend_q != 4'b0000) begin
          grant_d = top_bit(pend_q);
          do_d    = 1'b1;
          cnt_d   = RUN_LOAD;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (bus.abort) begin
          do_d    = 1'b0;
          sel_d   = SEL_CANCEL;
          cnt_d   = 8'd1;
          state_d = CANCEL;
        end else if (cnt_q == 8'd0) begin
          do_d    = 1'b0;
          sel_d   = SEL_COMMIT;
          cnt_d   = WAIT_LOAD;
          state_d = COMMIT;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      COMMIT: begin
        if (bus.f) begin
          sel_d   = SEL_NEUTRAL;
          done_d  = 1'b1;
          clr     = 4'b0001 << grant_q;
          state_d = IDLE;
        end else if (cnt_q == 8'd0) begin
          // Timeout leaves the request pending so it is retried.
          sel_d   = SEL_NEUTRAL;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      CANCEL: begin
        if (cnt_q == 8'd0) begin
          sel_d   = SEL_NEUTRAL;
          clr     = 4'b0001 << grant_q;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
        do_d    = 1'b0;
        sel_d   = SEL_NEUTRAL;
        grant_d = 2'd0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= 4'b0000;
      cnt_q   <= 8'd0;
      do_q    <= 1'b0;
      sel_q   <= SEL_NEUTRAL;
      grant_q <= 2'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      // A set and clear of the same bit in one cycle resolves to set.
      pend_q  <= (pend_q & ~clr) | bus.req;
      cnt_q   <= cnt_d;
      do_q    <= do_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.do_run = do_q;
  assign bus.sel    = sel_q;
  assign bus.grant  = grant_q;
  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = done_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_priority_src.sv
// Self-checking bench for priority_src with a behavioural model of the
// downstream FSM (IDLE -> MIDDLE -> LAST) supplying f.
module tb_priority_src;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  logic f_block = 1'b0;

  always #5 clk = ~clk;

  priority_src_if bus ();

  priority_src #(.RUN_LEN(4), .WAIT_MAX(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Downstream model: leaves IDLE when do is low with a non-neutral sel,
  // goes to LAST on commit and back to IDLE on cancel; f is high in LAST.
  typedef enum logic [1:0] {DS_IDLE, DS_MIDDLE, DS_LAST} ds_t;
  ds_t ds = DS_IDLE;

  always @(posedge clk) begin
    if (!rst_n) ds <= DS_IDLE;
    else begin
      case (ds)
        DS_IDLE:   if (!bus.do_run && bus.sel != 2'd0) ds <= DS_MIDDLE;
        DS_MIDDLE: ds <= (bus.sel == 2'd3) ? DS_LAST : DS_IDLE;
        default:   ds <= DS_IDLE;
      endcase
    end
  end

  assign bus.f = (ds == DS_LAST) && !f_block;

  typedef struct {
    logic [3:0]  req;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[$];

  // Packs {do, sel, grant, busy, done, err, pend}.
  function automatic logic [11:0] o(input logic d, input logic [1:0] s, input logic [1:0] g,
                                    input logic b, input logic dn, input logic e, input logic [3:0] p);
    return {d, s, g, b, dn, e, p};
  endfunction

  function automatic logic [11:0] cur();
    return {bus.do_run, bus.sel, bus.grant, bus.busy, bus.done, bus.err, dut.pend_q};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] r, input logic [11:0] e, input int k);
    for (int i = 0; i < k; i++) vecs.push_back('{r, e});
  endtask

  task automatic cyc(input logic [3:0] r, input logic a);
    bus.req   = r;
    bus.abort = a;
    @(posedge clk);
    #1;
  endtask

  task automatic step_chk(input string name, input logic [3:0] r, input logic a, input logic [11:0] e);
    cyc(r, a);
    check(name, 32'(cur()), 32'(e));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    bus.req   = 4'b0000;
    bus.abort = 1'b0;
    cyc(4'b0000, 1'b0);
    cyc(4'b0000, 1'b0);
    check("reset_state", 32'(cur()), 32'(o(0, 0, 0, 0, 0, 0, 4'b0000)));
    rst_n = 1'b1;

    // Single commit on source 1, then 4'b1001 served as grant 3 then grant 0.
    add(4'b0010, o(0, 0, 1'b0 ? 2'd0 : 2'd0, 0, 0, 0, 4'b0010), 1);
    add(4'b0000, o(1, 0, 1, 1, 0, 0, 4'b0010), 4);
    add(4'b0000, o(0, 3, 1, 1, 0, 0, 4'b0010), 3);
    add(4'b0000, o(0, 0, 1, 0, 1, 0, 4'b0000), 1);
    add(4'b0000, o(0, 0, 1, 0, 0, 0, 4'b0000), 1);
    add(4'b1001, o(0, 0, 1, 0, 0, 0, 4'b1001), 1);
    add(4'b0000, o(1, 0, 3, 1, 0, 0, 4'b1001), 4);
    add(4'b0000, o(0, 3, 3, 1, 0, 0, 4'b1001), 3);
    add(4'b0000, o(0, 0, 3, 0, 1, 0, 4'b0001), 1);
    add(4'b0000, o(1, 0, 0, 1, 0, 0, 4'b0001), 4);
    add(4'b0000, o(0, 3, 0, 1, 0, 0, 4'b0001), 3);
    add(4'b0000, o(0, 0, 0, 0, 1, 0, 4'b0000), 1);
    add(4'b0000, o(0, 0, 0, 0, 0, 0, 4'b0000), 1);

    foreach (vecs[i]) begin
      cyc(vecs[i].req, 1'b0);
      check($sformatf("vec[%0d]", i), 32'(cur()), 32'(vecs[i].exp));
    end

    // Abort on the second DRIVE cycle of a grant to source 2.
    step_chk("abort_req",    4'b0100, 1'b0, o(0, 0, 0, 0, 0, 0, 4'b0100));
    step_chk("abort_drv1",   4'b0000, 1'b0, o(1, 0, 2, 1, 0, 0, 4'b0100));
    step_chk("abort_drv2",   4'b0000, 1'b0, o(1, 0, 2, 1, 0, 0, 4'b0100));
    step_chk("abort_c0",     4'b0000, 1'b1, o(0, 2, 2, 1, 0, 0, 4'b0100));
    step_chk("abort_c1",     4'b0000, 1'b0, o(0, 2, 2, 1, 0, 0, 4'b0100));
    check("abort_no_f1", 32'(bus.f), 32'd0);
    step_chk("abort_c2",     4'b0000, 1'b0, o(0, 0, 2, 0, 0, 0, 4'b0000));
    check("abort_no_f2", 32'(bus.f), 32'd0);
    check("abort_ds_idle", 32'(ds == DS_IDLE), 32'd1);
    step_chk("abort_after",  4'b0000, 1'b0, o(0, 0, 2, 0, 0, 0, 4'b0000));

    // Timeout with f held low, then automatic regrant.
    f_block = 1'b1;
    step_chk("to_req",       4'b0001, 1'b0, o(0, 0, 2, 0, 0, 0, 4'b0001));
    for (int i = 0; i < 4; i++)
      step_chk($sformatf("to_drive%0d", i), 4'b0000, 1'b0, o(1, 0, 0, 1, 0, 0, 4'b0001));
    for (int i = 0; i < 8; i++)
      step_chk($sformatf("to_commit%0d", i), 4'b0000, 1'b0, o(0, 3, 0, 1, 0, 0, 4'b0001));
    step_chk("to_err",       4'b0000, 1'b0, o(0, 0, 0, 0, 0, 1, 4'b0001));
    f_block = 1'b0;
    for (int i = 0; i < 4; i++)
      step_chk($sformatf("regrant_drive%0d", i), 4'b0000, 1'b0, o(1, 0, 0, 1, 0, 0, 4'b0001));
    for (int i = 0; i < 3; i++)
      step_chk($sformatf("regrant_commit%0d", i), 4'b0000, 1'b0, o(0, 3, 0, 1, 0, 0, 4'b0001));

    // Re-request the granted bit on the same edge that clears it.
    step_chk("collide_done", 4'b0001, 1'b0, o(0, 0, 0, 0, 1, 0, 4'b0001));
    step_chk("collide_regrant", 4'b0000, 1'b0, o(1, 0, 0, 1, 0, 0, 4'b0001));
    step_chk("collide_drive", 4'b0000, 1'b0, o(1, 0, 0, 1, 0, 0, 4'b0001));

    // Reset in the middle of DRIVE abandons the grant silently.
    rst_n = 1'b0;
    step_chk("midrst",       4'b0000, 1'b0, o(0, 0, 0, 0, 0, 0, 4'b0000));
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++)
      step_chk($sformatf("post_rst%0d", i), 4'b0000, 1'b0, o(0, 0, 0, 0, 0, 0, 4'b0000));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/priority_src.md
# priority_src

Request arbiter and sequencer that sits directly upstream of the `priority_1` control FSM and generates its `do`/`sel` stimulus. It collects sticky requests from four sources and grants the highest-priority one. For each grant it drives `do` high for a fixed run length, then steers the downstream FSM into LAST (commit) or back to IDLE (abort). It consumes the downstream `f` pulse as completion acknowledge.

## Interface
- `RUN_LEN`, default 4: cycles `do` is held high per grant; legal range 1..15.
- `WAIT_MAX`, default 8: cycles to wait for `f` after commit before flagging a timeout; legal range 3..255.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req` in 4: request pulses; bit 3 is highest priority.
- `abort` in 1: cancel the current grant; honoured only in DRIVE.
- `f` in 1: completion flag from the downstream FSM (high while it is in LAST).
- `do` out 1: run strobe to the downstream FSM.
- `sel` out 2: steering code to the downstream FSM; 2'd3 = commit, 2'd2 = cancel, 2'd0 = neutral.
- `grant` out 2: index of the request currently being served.
- `busy` out 1: high whenever state is not IDLE.
- `done` out 1: one-cycle pulse on a committed completion.
- `err` out 1: one-cycle pulse on commit timeout.

## Operation
- **Pending register.** `pend[3:0]` is updated every cycle as `pend <= (pend & ~clr) | req`. If the same bit is set and cleared in one cycle, set wins.
- **States:** IDLE, DRIVE, COMMIT, CANCEL. All outputs are registered.
- **IDLE**
  - If `pend != 0`: latch `grant` = highest set bit, set `do` <= 1, load `cnt` <= RUN_LEN-1, go to DRIVE.
  - `pend` is sampled before this cycle's `req` merge, so a `req` seen in the same cycle is granted one cycle later.
- **DRIVE**
  - If `abort` = 1: `do` <= 0, `sel` <= 2, `cnt` <= 1, go to CANCEL.
  - Else if `cnt` == 0: `do` <= 0, `sel` <= 3, `cnt` <= WAIT_MAX-1, go to COMMIT.
  - Else: `cnt` decrements.
  - `abort` on the final DRIVE cycle takes priority over commit.
- **COMMIT**
  - If `f` = 1: `sel` <= 0, `done` <= 1 for one cycle, clear `pend[grant]`, go to IDLE.
  - Else if `cnt` == 0: `sel` <= 0, `err` <= 1 for one cycle, `pend` is left unchanged (the request is retried), go to IDLE.
  - Else: `cnt` decrements.
- **CANCEL**
  - Hold `sel` = 2 for 2 cycles, then `sel` <= 0, clear `pend[grant]`, go to IDLE.
  - `done` is not pulsed.
- `f` is ignored outside COMMIT. `abort` is ignored outside DRIVE.
- `grant` holds its value until the next grant is made. `busy` is derived from the registered state.
- Illegal state encoding recovers to IDLE with all outputs cleared.

## Timing
- **Reset:** `rst_n` = 0 at an edge sets state = IDLE, `pend` = 0, `cnt` = 0, and `do`, `sel`, `grant`, `busy`, `done`, `err` all to 0. A reset mid-grant abandons the grant with no `done`/`err` pulse.
- **Issue latency:** `req` pulse at edge N sets `pend`; `do` rises at edge N+1 and stays high for exactly RUN_LEN cycles.
- **Downstream handshake:** `do` falls at edge D together with `sel` = 3.
  - Downstream enters MIDDLE at D+1 and LAST at D+2, so `f` is high in cycle D+2.
  - `done` rises at D+3, and the block is back in IDLE at D+3.
- **Back-to-back grants:** the next `do` rises no earlier than D+4, by which time downstream has returned to IDLE.
- **Cancel:** `do` falls at edge C with `sel` = 2. Downstream is in MIDDLE at C+1 and IDLE at C+2. `sel` returns to 0 at C+2 and this block reaches IDLE at C+2.
- **Timeout:** with no `f`, `err` pulses WAIT_MAX cycles after entry to COMMIT.

## Test plan
- **Single commit:** reset, then `req` = 4'b0010 pulse. Expect `grant` = 1, `do` high 4 cycles, `sel` = 3, `f` high 2 cycles after `do` falls, `done` pulse one cycle later, `pend` = 0, `busy` low.
- **Priority:** `req` = 4'b1001 pulse. Expect `grant` = 3 served first with `done`, then `grant` = 0 served, two `done` pulses in total.
- **Abort:** `abort` = 1 on the 2nd DRIVE cycle. Expect `do` = 0, `sel` = 2 for 2 cycles, downstream back to IDLE, no `f`, no `done`, `pend` bit cleared.
- **Timeout:** hold the downstream `f` at 0. Expect `err` pulse 8 cycles after COMMIT entry, `pend` bit still set, automatic regrant.
- **Set/clear collision:** re-pulse `req[grant]` in the cycle `done` is generated. Expect the bit to remain pending and be granted again.
- **Mid-run reset:** assert `rst_n` = 0 during DRIVE. Expect all outputs 0 at the next edge and no `done`/`err`.
